pc_stack: RTL and testbench

- Parametrised program counter for the Hack-style CPU datapath, successor to the single-bit gate primitives.
- Adds width generalisation, a configurable increment step and a hardware call/return LIFO of configurable depth.
- Sits between the instruction decoder (control strobes) and the instruction-memory address bus (`out`).

---
 rtl/pc_pkg.sv | 35 +++
 rtl/lifo_stack.sv | 70 +++++++
 rtl/pc_stack.sv | 106 ++++++++++
 tb/tb_pc_stack.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// ---------------------------------------------------------------------------
// pc_pkg
//   Shared definitions for the program-counter block.
//   - action_t      : the single action taken on a clock edge
//   - decode_action : fixed-priority encode of the decoder strobes
//                     (clr > ret > call > load > inc > hold)
// ---------------------------------------------------------------------------
package pc_pkg;

   typedef enum logic [2:0] {
      ACT_HOLD = 3'd0,
      ACT_CLR  = 3'd1,
      ACT_RET  = 3'd2,
      ACT_CALL = 3'd3,
      ACT_LOAD = 3'd4,
      ACT_INC  = 3'd5
   } action_t;

   // Lower-priority strobes that arrive with a higher one are simply dropped.
   function automatic action_t decode_action(input logic clr,
                                             input logic ret,
                                             input logic call,
                                             input logic load,
                                             input logic inc);
      action_t act;
      act = ACT_HOLD;
      if (clr)       act = ACT_CLR;
      else if (ret)  act = ACT_RET;
      else if (call) act = ACT_CALL;
      else if (load) act = ACT_LOAD;
      else if (inc)  act = ACT_INC;
      return act;
   endfunction

endpackage

// File: rtl/lifo_stack.sv
// ---------------------------------------------------------------------------
// lifo_stack
//   Return-address LIFO of DEPTH entries, WIDTH bits each.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset (clears level)
//     clr        : synchronous clear of the level (storage left as is)
//     push       : write wdata at position level, level+1 (ignored when full)
//     pop        : level-1 (ignored when empty)
//     wdata      : data to push
//     top        : entry[level-1], 0 when empty (combinational)
//     level      : number of valid entries
//     full/empty : level == DEPTH / level == 0
//   push and pop are never asserted together by the caller.
// ---------------------------------------------------------------------------
module lifo_stack
   import pc_pkg::*;
#(
   parameter  int WIDTH = 16,
   parameter  int DEPTH = 8,
   localparam int LW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] top,
   output logic [LW-1:0]    level,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign full    = (level == LW'(DEPTH));
   assign empty   = (level == '0);
   assign do_push = push && !full && !clr;
   assign do_pop  = pop && !empty && !clr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       level <= '0;
      else if (clr)     level <= '0;
      else if (do_push) level <= level + LW'(1);
      else if (do_pop)  level <= level - LW'(1);
   end

   // Storage needs no reset: entries above level are never observed.
   // Compare against level per slot rather than indexing with it, so the
   // index width never has to match the array size.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (do_push && (level == LW'(i))) mem[i] <= wdata;
      end
   end

   always_comb begin
      top = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (level == LW'(i + 1)) top = mem[i];
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n) assert (!(push && pop));
   end

endmodule

// File: rtl/pc_stack.sv
// ---------------------------------------------------------------------------
// pc_stack
//   Program counter with configurable step and hardware call/return LIFO.
//   Ports:
//     clk, rst_n      : clock, asynchronous active-low reset
//     clr             : clear counter, level and error flags
//     load            : out <= addr
//     inc             : out <= out + STEP
//     call            : push out+STEP, out <= addr (suppressed when full)
//     ret             : out <= top, pop (suppressed when empty)
//     addr            : jump/call target
//     out             : current program counter
//     top, level      : LIFO top entry (0 when empty) and fill level
//     empty, full     : LIFO status
//     err_ovf/err_unf : sticky call-while-full / ret-while-empty flags
//   Exactly one action per edge: clr > ret > call > load > inc > hold.
// ---------------------------------------------------------------------------
module pc_stack
   import pc_pkg::*;
#(
   parameter  int WIDTH = 16,
   parameter  int DEPTH = 8,
   parameter  int STEP  = 1,
   localparam int LW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             load,
   input  logic             inc,
   input  logic             call,
   input  logic             ret,
   input  logic [WIDTH-1:0] addr,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] top,
   output logic [LW-1:0]    level,
   output logic             empty,
   output logic             full,
   output logic             err_ovf,
   output logic             err_unf
);

   // Truncating the step gives the modulo-2^WIDTH increment for free.
   localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

   action_t          act;
   logic             push;
   logic             pop;
   logic             lifo_clr;
   logic [WIDTH-1:0] next_seq;

   assign next_seq = out + STEP_W;

   always_comb begin
      act      = decode_action(clr, ret, call, load, inc);
      push     = (act == ACT_CALL) && !full;
      pop      = (act == ACT_RET) && !empty;
      lifo_clr = (act == ACT_CLR);
   end

   lifo_stack #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_lifo (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (lifo_clr),
      .push  (push),
      .pop   (pop),
      .wdata (next_seq),
      .top   (top),
      .level (level),
      .full  (full),
      .empty (empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out     <= '0;
         err_ovf <= 1'b0;
         err_unf <= 1'b0;
      end else begin
         case (act)
            ACT_CLR: begin
               out     <= '0;
               err_ovf <= 1'b0;
               err_unf <= 1'b0;
            end
            ACT_RET: begin
               if (!empty) out     <= top;
               else        err_unf <= 1'b1;
            end
            ACT_CALL: begin
               // A call that cannot push must not jump either, or the
               // matching ret would land somewhere unrelated.
               if (!full) out     <= addr;
               else       err_ovf <= 1'b1;
            end
            ACT_LOAD: out <= addr;
            ACT_INC:  out <= next_seq;
            default:  ;
         endcase
      end
   end

endmodule

// File: tb/tb_pc_stack.sv
module tb_pc_stack;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clr = 0, load = 0, inc = 0, call = 0, ret = 0;
   logic [15:0] addr = '0;

   // DUT A: defaults (DEPTH 8, STEP 1); DUT B: DEPTH 2, STEP 2. Shared stimulus.
   logic [15:0] a_out, a_top, b_out, b_top;
   logic [3:0]  a_level;
   logic [1:0]  b_level;
   logic        a_empty, a_full, a_ovf, a_unf;
   logic        b_empty, b_full, b_ovf, b_unf;

   pc_stack #(.WIDTH(16), .DEPTH(8), .STEP(1)) u_a (
      .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .inc(inc), .call(call),
      .ret(ret), .addr(addr), .out(a_out), .top(a_top), .level(a_level),
      .empty(a_empty), .full(a_full), .err_ovf(a_ovf), .err_unf(a_unf));

   pc_stack #(.WIDTH(16), .DEPTH(2), .STEP(2)) u_b (
      .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .inc(inc), .call(call),
      .ret(ret), .addr(addr), .out(b_out), .top(b_top), .level(b_level),
      .empty(b_empty), .full(b_full), .err_ovf(b_ovf), .err_unf(b_unf));

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // ---------------- reference model (one per DUT) ----------------
   int          dep  [2] = '{8, 2};
   int          stp  [2] = '{1, 2};
   logic [15:0] m_out[2];
   logic [15:0] m_mem[2][8];
   int          m_lvl[2];
   bit          m_ovf[2], m_unf[2];

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_out[k] = '0; m_lvl[k] = 0; m_ovf[k] = 0; m_unf[k] = 0;
      end
   endtask

   task automatic model_step();
      for (int k = 0; k < 2; k++) begin
         if (clr) begin
            m_out[k] = '0; m_lvl[k] = 0; m_ovf[k] = 0; m_unf[k] = 0;
         end else if (ret) begin
            if (m_lvl[k] == 0) m_unf[k] = 1;
            else begin
               m_lvl[k]--;
               m_out[k] = m_mem[k][m_lvl[k]];
            end
         end else if (call) begin
            if (m_lvl[k] == dep[k]) m_ovf[k] = 1;
            else begin
               m_mem[k][m_lvl[k]] = 16'(m_out[k] + stp[k]);
               m_lvl[k]++;
               m_out[k] = addr;
            end
         end else if (load) m_out[k] = addr;
         else if (inc)      m_out[k] = 16'(m_out[k] + stp[k]);
      end
   endtask

   // ---------------- checking ----------------
   task automatic chk(input string n, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
      end
   endtask

   task automatic chk_dut(input string n, input int k, input logic [15:0] o,
                          input logic [15:0] t, input int lvl, input logic e,
                          input logic f, input logic ov, input logic un);
      logic [15:0] et;
      et = (m_lvl[k] == 0) ? 16'h0 : m_mem[k][m_lvl[k]-1];
      chk({n, ".out"},   int'(o),  int'(m_out[k]));
      chk({n, ".top"},   int'(t),  int'(et));
      chk({n, ".level"}, lvl,      m_lvl[k]);
      chk({n, ".empty"}, int'(e),  int'(m_lvl[k] == 0));
      chk({n, ".full"},  int'(f),  int'(m_lvl[k] == dep[k]));
      chk({n, ".ovf"},   int'(ov), int'(m_ovf[k]));
      chk({n, ".unf"},   int'(un), int'(m_unf[k]));
   endtask

   task automatic chk_model();
      chk_dut("A", 0, a_out, a_top, int'(a_level), a_empty, a_full, a_ovf, a_unf);
      chk_dut("B", 1, b_out, b_top, int'(b_level), b_empty, b_full, b_ovf, b_unf);
   endtask

   // strobe bit order: {clr, ret, call, load, inc}
   task automatic drive(input logic [4:0] s, input logic [15:0] a);
      {clr, ret, call, load, inc} = s;
      addr = a;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
      model_step();
      chk_model();
   endtask

   // ---------------- table-driven vectors (expected for DUT A) ----------------
   typedef struct {
      logic [4:0]  s;
      logic [15:0] a;
      logic [15:0] e_out;
      int          e_lvl;
      logic [15:0] e_top;
      logic        e_ovf;
      logic        e_unf;
   } vec_t;

   vec_t vecs[17];

   initial begin
      vecs[0]  = '{5'b00001, 16'h0000, 16'h0001, 0, 16'h0000, 1'b0, 1'b0};
      vecs[1]  = '{5'b00001, 16'h0000, 16'h0002, 0, 16'h0000, 1'b0, 1'b0};
      vecs[2]  = '{5'b00001, 16'h0000, 16'h0003, 0, 16'h0000, 1'b0, 1'b0};
      vecs[3]  = '{5'b00010, 16'hFFFE, 16'hFFFE, 0, 16'h0000, 1'b0, 1'b0};
      vecs[4]  = '{5'b00001, 16'h0000, 16'hFFFF, 0, 16'h0000, 1'b0, 1'b0};
      vecs[5]  = '{5'b00001, 16'h0000, 16'h0000, 0, 16'h0000, 1'b0, 1'b0};
      vecs[6]  = '{5'b00010, 16'h0010, 16'h0010, 0, 16'h0000, 1'b0, 1'b0};
      vecs[7]  = '{5'b00100, 16'h0100, 16'h0100, 1, 16'h0011, 1'b0, 1'b0};
      vecs[8]  = '{5'b00100, 16'h0200, 16'h0200, 2, 16'h0101, 1'b0, 1'b0};
      vecs[9]  = '{5'b01000, 16'h0000, 16'h0101, 1, 16'h0011, 1'b0, 1'b0};
      vecs[10] = '{5'b01000, 16'h0000, 16'h0011, 0, 16'h0000, 1'b0, 1'b0};
      vecs[11] = '{5'b00111, 16'h0040, 16'h0040, 1, 16'h0012, 1'b0, 1'b0};
      vecs[12] = '{5'b00011, 16'h0007, 16'h0007, 1, 16'h0012, 1'b0, 1'b0};
      vecs[13] = '{5'b11111, 16'h0055, 16'h0000, 0, 16'h0000, 1'b0, 1'b0};
      vecs[14] = '{5'b01000, 16'h0000, 16'h0000, 0, 16'h0000, 1'b0, 1'b1};
      vecs[15] = '{5'b00001, 16'h0000, 16'h0001, 0, 16'h0000, 1'b0, 1'b1};
      vecs[16] = '{5'b10000, 16'h0000, 16'h0000, 0, 16'h0000, 1'b0, 1'b0};
   end

   // ---------------- main sequence ----------------
   initial begin
      model_reset();
      #3;
      // reset values while rst_n is low
      chk_model();
      chk("rst.A.empty", int'(a_empty), 1);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;

      // build state: one push, then count to 5; then asynchronous reset
      drive(5'b00100, 16'h0000); cyc();
      for (int i = 0; i < 5; i++) begin drive(5'b00001, 16'h0); cyc(); end
      chk("pre_rst.A.out", int'(a_out), 16'h0005);
      chk("pre_rst.A.level", int'(a_level), 1);
      drive(5'b00000, 16'h0);
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("async_rst.A.out", int'(a_out), 0);
      chk("async_rst.A.level", int'(a_level), 0);
      chk("async_rst.A.empty", int'(a_empty), 1);
      chk_model();
      #1 rst_n = 1'b1;

      // table vectors
      for (int i = 0; i < 17; i++) begin
         drive(vecs[i].s, vecs[i].a);
         cyc();
         chk($sformatf("vec%0d.out", i),   int'(a_out),   int'(vecs[i].e_out));
         chk($sformatf("vec%0d.level", i), int'(a_level), vecs[i].e_lvl);
         chk($sformatf("vec%0d.top", i),   int'(a_top),   int'(vecs[i].e_top));
         chk($sformatf("vec%0d.ovf", i),   int'(a_ovf),   int'(vecs[i].e_ovf));
         chk($sformatf("vec%0d.unf", i),   int'(a_unf),   int'(vecs[i].e_unf));
      end

      // STEP = 2 wrap on DUT B
      drive(5'b00010, 16'hFFFF); cyc();
      drive(5'b00001, 16'h0000); cyc();
      chk("wrap2.B.out", int'(b_out), 16'h0001);

      // overflow / underflow on DUT B (DEPTH 2, STEP 2)
      drive(5'b10000, 16'h0); cyc();
      drive(5'b00100, 16'h0010); cyc();
      drive(5'b00100, 16'h0020); cyc();
      chk("ovf.B.full_before", int'(b_full), 1);
      drive(5'b00100, 16'h0030); cyc();
      chk("ovf.B.out", int'(b_out), 16'h0020);
      chk("ovf.B.level", int'(b_level), 2);
      chk("ovf.B.flag", int'(b_ovf), 1);
      drive(5'b01000, 16'h0); cyc();
      chk("ret1.B.out", int'(b_out), 16'h0012);
      cyc();
      chk("ret2.B.out", int'(b_out), 16'h0002);
      cyc();
      chk("ret3.B.out", int'(b_out), 16'h0002);
      chk("ret3.B.unf", int'(b_unf), 1);

      // hold: 10 idle edges, flags sticky
      drive(5'b00000, 16'h1234);
      for (int i = 0; i < 10; i++) begin
         cyc();
         chk("hold.B.out", int'(b_out), 16'h0002);
         chk("hold.B.flags", int'({b_ovf, b_unf}), 3);
      end
      drive(5'b10000, 16'h0); cyc();
      chk("clr.B.out", int'(b_out), 0);
      chk("clr.B.flags", int'({b_ovf, b_unf}), 0);

      // random soak against the model
      for (int i = 0; i < 1500; i++) begin
         logic [4:0] s;
         s[4] = ($urandom_range(0, 59) == 0);
         s[3] = ($urandom_range(0, 3) == 0);
         s[2] = ($urandom_range(0, 2) == 0);
         s[1] = ($urandom_range(0, 7) == 0);
         s[0] = ($urandom_range(0, 1) == 0);
         drive(s, 16'($urandom));
         cyc();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
